periph_bus_bridge: RTL and testbench
====================================

Name: periph_bus_bridge

Overview:
Parametrised memory-mapped interconnect between the processor's single read/write bus and N peripherals (GPU, SD card, keyboard, extension board, LEDs). It decodes the address into a one-hot slave select, runs a request/acknowledge handshake with the selected slave, and returns read data with a ready pulse. Accesses that are undecodable, time out, or request both read and write complete with an error. The block sits in the board top level between the processor and all peripherals.

Parameters:
NUM_SLAVES, 4, number of peripheral channels (1..16)
DATA_WIDTH, 64, bus data width
ADDR_WIDTH, 64, processor address width
SLOT_BITS, 12, per-slave window size in address bits (each slave gets 2^SLOT_BITS bytes)
BASE_ADDR, 64'hFFFF_0000, base of the peripheral region; aligned to 2^(SLOT_BITS+SEL_BITS)
TIMEOUT_CYCLES, 255, maximum cycles waiting for slave ack (1..65535)
Derived constant: SEL_BITS = max(1, clog2(NUM_SLAVES)).

Ports:
clock  in  1  system clock (CLOCK_50 at the top level)
reset_n  in  1  asynchronous active-low reset
cpu_addr  in  ADDR_WIDTH  processor address
cpu_wdata  in  DATA_WIDTH  processor write data
cpu_read  in  1  read request level, held until cpu_ready
cpu_write  in  1  write request level, held until cpu_ready
cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
cpu_error  out  1  qualifies cpu_ready: access failed
slv_sel  out  NUM_SLAVES  one-hot slave select
slv_addr  out  SLOT_BITS  offset within the slave window
slv_wdata  out  DATA_WIDTH  write data to slaves
slv_read  out  1  read strobe, held until ack
slv_write  out  1  write strobe, held until ack
slv_rdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
slv_ack  in  NUM_SLAVES  per-slave acknowledge
err_addr  out  ADDR_WIDTH  address of the most recent failed access
err_count  out  8  saturating count of failed accesses

Behaviour:
- Reset (asynchronous, reset_n=0): FSM to IDLE; all outputs 0; counters cleared. Reset mid-access drops slv_* immediately. The slave sees an aborted access, and no completion is issued.
- FSM states: IDLE, ACCESS, RESP, RELEASE.
- IDLE: on a clock edge where cpu_read|cpu_write=1, latch addr, wdata and direction.
  - Both read and write high -> RESP with error.
  - Region mismatch (cpu_addr[ADDR_WIDTH-1:SLOT_BITS+SEL_BITS] differs from the same bits of BASE_ADDR) -> RESP with error.
  - Index = cpu_addr[SLOT_BITS +: SEL_BITS]. Index >= NUM_SLAVES -> RESP with error.
  - Otherwise -> ACCESS with the timeout counter cleared.
- ACCESS:
  - slv_sel is one-hot at the latched index; slv_read or slv_write is 1; slv_addr and slv_wdata come from the latches. All of these are registered and stable for the whole state.
  - Only slv_ack[index] is honoured; acks from other slaves are ignored.
  - Ack sampled high -> capture slv_rdata[index] for reads (hold previous value for writes), then go to RESP without error.
  - Counter reaches TIMEOUT_CYCLES with no ack -> RESP with error.
  - Ack on the same edge as the timeout: the ack wins.
- RESP: cpu_ready=1 for exactly one cycle; cpu_error per the outcome. On error, cpu_rdata = all ones. slv_* outputs are 0. Go to RELEASE.
- RELEASE: wait until cpu_read=cpu_write=0, then go to IDLE. A held request never starts a second transaction.
- Latency: request sampled at edge 0; slv strobes visible after edge 0. Ack sampled at edge k -> cpu_ready high in the cycle after edge k. A zero-wait slave (ack combinational on strobe) gives cpu_ready 2 cycles after the request. Decode errors give cpu_ready 1 cycle after the request.
- Error logging: on every error completion, err_addr <= latched address and err_count increments, saturating at 255.
- Request dropped by the CPU during ACCESS: the access still completes normally (protocol violation, not detected).

Decomposition:
- Shared package bus_pkg: state enum (IDLE/ACCESS/RESP/RELEASE), ERR_RDATA all-ones constant, a clog2-based SEL_BITS helper, and a default BASE_ADDR.
- One sub-module, bus_addr_decoder: purely combinational region check, index extraction, range check, and one-hot generation. The bridge FSM stays in periph_bus_bridge.

Test Plan:
- Zero-wait read: NUM_SLAVES=4, BASE=FFFF_0000; read 0xFFFF_1008; slave1 acks immediately with 0x1234 -> slv_sel=0010, slv_addr=0x008; cpu_ready at cycle 2 with cpu_rdata=0x1234, cpu_error=0.
- Wait-state write: write 0xDEAD to 0xFFFF_3000; slave3 acks after 5 cycles -> slv_write held 6 cycles with slv_wdata=0xDEAD; then a single cpu_ready pulse, cpu_error=0.
- Decode error: read 0x0000_1000 -> cpu_ready at cycle 1 with cpu_error=1, rdata all ones, no slv strobe, err_addr=0x1000, err_count=1. With NUM_SLAVES=3, a read of 0xFFFF_3000 gives the same result.
- Timeout: TIMEOUT_CYCLES=8; slave2 never acks -> error completion after 8 ACCESS cycles. Repeat 300 times -> err_count saturates at 255.
- Handshake hygiene: hold cpu_read high for 10 cycles after ready -> exactly one transaction. Both read and write high -> error, no strobe. Ack on the timeout edge -> success.
- Reset mid-access: deassert reset_n during ACCESS -> slv_read and slv_sel go to 0 asynchronously, no cpu_ready; after release, the next read completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the processor-to-peripheral bus bridge.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } bus_state_e;

  localparam logic [63:0]   DEFAULT_BASE_ADDR = 64'hFFFF_0000;
  localparam logic [1023:0] ERR_RDATA         = '1;

  // A single slave still needs one select bit so the index slice is never empty.
  function automatic int sel_bits(input int num_slaves);
    return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decode: region check, slave index range check and
// one-hot select generation, plus the in-window offset.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int                    NUM_SLAVES = 4,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    SLOT_BITS  = 12,
  parameter int                    SEL_BITS   = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [SLOT_BITS-1:0]  offset
);

  localparam int REGION_LSB = SLOT_BITS + SEL_BITS;

  logic                region_ok;
  logic [SEL_BITS-1:0] index;

  assign region_ok = (addr[ADDR_WIDTH-1:REGION_LSB] == BASE_ADDR[ADDR_WIDTH-1:REGION_LSB]);
  assign index     = addr[SLOT_BITS +: SEL_BITS];
  assign offset    = addr[SLOT_BITS-1:0];
  assign hit       = region_ok && (32'(index) < NUM_SLAVES);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = hit && (32'(index) == i);
    end
  end

endmodule

// File: rtl/periph_bus_bridge.sv
// Bridge between the processor read/write bus and the peripheral slaves:
// decode, request/ack handshake with timeout, error completion and logging.
module periph_bus_bridge
  import bus_pkg::*;
#(
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    DATA_WIDTH     = 64,
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    SLOT_BITS      = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  input  logic                             cpu_read,
  input  logic                             cpu_write,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  output logic                             cpu_ready,
  output logic                             cpu_error,
  output logic [NUM_SLAVES-1:0]            slv_sel,
  output logic [SLOT_BITS-1:0]             slv_addr,
  output logic [DATA_WIDTH-1:0]            slv_wdata,
  output logic                             slv_read,
  output logic                             slv_write,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]            slv_ack,
  output logic [ADDR_WIDTH-1:0]            err_addr,
  output logic [7:0]                       err_count
);

  localparam int SEL_BITS = sel_bits(NUM_SLAVES);

  bus_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NUM_SLAVES-1:0]  sel_q, sel_d;
  logic [SLOT_BITS-1:0]   slv_addr_q, slv_addr_d;
  logic [DATA_WIDTH-1:0]  slv_wdata_q, slv_wdata_d;
  logic                   slv_read_q, slv_read_d;
  logic                   slv_write_q, slv_write_d;
  logic [15:0]            timer_q, timer_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   ready_q, ready_d;
  logic                   error_q, error_d;
  logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
  logic [7:0]             err_count_q, err_count_d;

  logic                   dec_hit;
  logic [NUM_SLAVES-1:0]  dec_sel;
  logic [SLOT_BITS-1:0]   dec_offset;
  logic                   ack_hit;
  logic [DATA_WIDTH-1:0]  sel_rdata;
  logic                   fail;

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLOT_BITS  (SLOT_BITS),
    .SEL_BITS   (SEL_BITS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_decoder (
    .addr   (cpu_addr),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .offset (dec_offset)
  );

  // sel_q is only non-zero in ACCESS, so acks from unselected slaves fall out here.
  always_comb begin
    ack_hit   = |(slv_ack & sel_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | slv_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    slv_read_d  = slv_read_q;
    slv_write_d = slv_write_q;
    timer_d     = timer_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    error_d     = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    fail        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          addr_d = cpu_addr;
          if ((cpu_read && cpu_write) || !dec_hit) begin
            state_d = RESP;
            ready_d = 1'b1;
            fail    = 1'b1;
          end else begin
            state_d     = ACCESS;
            sel_d       = dec_sel;
            slv_addr_d  = dec_offset;
            slv_wdata_d = cpu_wdata;
            slv_read_d  = cpu_read;
            slv_write_d = cpu_write;
            timer_d     = '0;
          end
        end
      end
      ACCESS: begin
        // Ack is tested before the timeout so an ack on the final cycle still succeeds.
        if (ack_hit || (timer_q + 16'd1 == 16'(TIMEOUT_CYCLES))) begin
          state_d     = RESP;
          ready_d     = 1'b1;
          fail        = !ack_hit;
          if (ack_hit && slv_read_q) rdata_d = sel_rdata;
          sel_d       = '0;
          slv_addr_d  = '0;
          slv_wdata_d = '0;
          slv_read_d  = 1'b0;
          slv_write_d = 1'b0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP:    state_d = RELEASE;
      RELEASE: if (!cpu_read && !cpu_write) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fail) begin
      error_d     = 1'b1;
      rdata_d     = ERR_RDATA[DATA_WIDTH-1:0];
      err_addr_d  = addr_d;
      err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sel_q       <= '0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
      slv_read_q  <= 1'b0;
      slv_write_q <= 1'b0;
      timer_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      slv_read_q  <= slv_read_d;
      slv_write_q <= slv_write_d;
      timer_q     <= timer_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_error = error_q;
  assign slv_sel   = sel_q;
  assign slv_addr  = slv_addr_q;
  assign slv_wdata = slv_wdata_q;
  assign slv_read  = slv_read_q;
  assign slv_write = slv_write_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Directed, table-driven bench for periph_bus_bridge: a 4-slave bridge with a
// short timeout, plus a 3-slave bridge for the index range check.
module tb_periph_bus_bridge;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock;
  logic        reset_n;

  // Main bridge: 4 slaves, timeout of 8 cycles.
  logic [63:0]  cpu_addr, cpu_wdata, cpu_rdata, err_addr;
  logic         cpu_read, cpu_write, cpu_ready, cpu_error;
  logic [3:0]   slv_sel, slv_ack;
  logic [11:0]  slv_addr;
  logic [63:0]  slv_wdata;
  logic         slv_read, slv_write;
  logic [255:0] slv_rdata;
  logic [7:0]   err_count;

  // Secondary bridge: 3 slaves, zero-wait acks.
  logic [63:0]  b_addr, b_rdata, b_err_addr, b_swdata;
  logic         b_read, b_ready, b_error, b_sread, b_swrite;
  logic [2:0]   b_sel, b_ack;
  logic [11:0]  b_saddr;
  logic [191:0] b_slv_rdata;
  logic [7:0]   b_err_count;

  int          ack_delay;
  logic        ack_foreign;
  int          strobe_age;
  int          n_applied;
  int          n_miscompares;
  int          exp_err_count;
  logic [63:0] exp_err_addr;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rd;
    logic        wr;
    int          ack_delay;
    logic        foreign;
    int          hold;
    logic [3:0]  exp_sel;
    logic [11:0] exp_saddr;
    logic        exp_error;
    logic [63:0] exp_rdata;
    int          exp_lat;
    int          exp_strobes;
  } vec_t;

  vec_t vecs[10];

  periph_bus_bridge #(
    .NUM_SLAVES(4), .DATA_WIDTH(64), .ADDR_WIDTH(64), .SLOT_BITS(12),
    .BASE_ADDR(64'hFFFF_0000), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_error(cpu_error),
    .slv_sel(slv_sel), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_read(slv_read), .slv_write(slv_write), .slv_rdata(slv_rdata), .slv_ack(slv_ack),
    .err_addr(err_addr), .err_count(err_count)
  );

  periph_bus_bridge #(
    .NUM_SLAVES(3), .DATA_WIDTH(64), .ADDR_WIDTH(64), .SLOT_BITS(12),
    .BASE_ADDR(64'hFFFF_0000), .TIMEOUT_CYCLES(255)
  ) dut_b (
    .clock(clock), .reset_n(reset_n),
    .cpu_addr(b_addr), .cpu_wdata(64'h0), .cpu_read(b_read), .cpu_write(1'b0),
    .cpu_rdata(b_rdata), .cpu_ready(b_ready), .cpu_error(b_error),
    .slv_sel(b_sel), .slv_addr(b_saddr), .slv_wdata(b_swdata),
    .slv_read(b_sread), .slv_write(b_swrite), .slv_rdata(b_slv_rdata), .slv_ack(b_ack),
    .err_addr(b_err_addr), .err_count(b_err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign slv_rdata   = {64'hCCC3, 64'hBBB2, 64'h1234, 64'hAAA0};
  assign b_slv_rdata = {64'h2222, 64'h1111, 64'h0000};
  assign b_ack       = (b_sread || b_swrite) ? b_sel : 3'b000;

  // Slave model: the selected slave acks once the strobe has been up ack_delay cycles.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    strobe_age <= 0;
    else if (slv_read || slv_write)  strobe_age <= strobe_age + 1;
    else                             strobe_age <= 0;
  end

  always_comb begin
    slv_ack = 4'b0000;
    if ((slv_read || slv_write) && (strobe_age >= ack_delay)) slv_ack = slv_sel;
    if (ack_foreign) slv_ack = slv_ack | ~slv_sel;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_applied++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int          cyc;
    int          strobes;
    int          lat;
    logic        got;
    logic        stable;
    logic        retrig;
    logic [3:0]  first_sel;
    logic [11:0] first_saddr;
    logic [63:0] first_wdata;
    logic        first_rd;
    logic        first_wr;
    logic [63:0] rdata;
    logic        err;
    cyc = 0; strobes = 0; lat = -1; got = 1'b0; stable = 1'b1; retrig = 1'b0;
    first_sel = '0; first_saddr = '0; first_wdata = '0; first_rd = 1'b0; first_wr = 1'b0;
    rdata = '0; err = 1'b0;
    cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_read = v.rd; cpu_write = v.wr;
    ack_delay = v.ack_delay; ack_foreign = v.foreign;
    while (!got && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (slv_read || slv_write) begin
        if (strobes == 0) begin
          first_sel = slv_sel; first_saddr = slv_addr; first_wdata = slv_wdata;
          first_rd = slv_read; first_wr = slv_write;
        end else if (slv_sel != first_sel || slv_addr != first_saddr ||
                     slv_wdata != first_wdata || slv_read != first_rd) begin
          stable = 1'b0;
        end
        strobes++;
      end
      if (cpu_ready) begin
        got = 1'b1; lat = cyc; rdata = cpu_rdata; err = cpu_error;
      end
    end
    if (v.exp_error) begin
      exp_err_addr  = v.addr;
      exp_err_count = (exp_err_count == 255) ? 255 : exp_err_count + 1;
    end
    checkOutput($sformatf("v%0d ready latency", idx), 64'(lat), 64'(v.exp_lat));
    checkOutput($sformatf("v%0d strobe cycles", idx), 64'(strobes), 64'(v.exp_strobes));
    checkOutput($sformatf("v%0d slv_sel", idx), 64'(first_sel), 64'(v.exp_sel));
    checkOutput($sformatf("v%0d slv_addr", idx), 64'(first_saddr), 64'(v.exp_saddr));
    checkOutput($sformatf("v%0d cpu_error", idx), 64'(err), 64'(v.exp_error));
    checkOutput($sformatf("v%0d cpu_rdata", idx), rdata, v.exp_rdata);
    checkOutput($sformatf("v%0d err_count", idx), 64'(err_count), 64'(exp_err_count));
    if (v.exp_error) checkOutput($sformatf("v%0d err_addr", idx), err_addr, exp_err_addr);
    if (strobes > 0) begin
      checkOutput($sformatf("v%0d strobe stable", idx), 64'(stable), 64'd1);
      checkOutput($sformatf("v%0d direction", idx), 64'({first_rd, first_wr}), 64'({v.rd, v.wr}));
      if (v.wr) checkOutput($sformatf("v%0d slv_wdata", idx), first_wdata, v.wdata);
    end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clock);
      if (cpu_ready || slv_read || slv_write) retrig = 1'b1;
    end
    checkOutput($sformatf("v%0d single completion", idx), 64'(retrig), 64'd0);
    cpu_read = 1'b0; cpu_write = 1'b0; ack_foreign = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic runB(input logic [63:0] addr, output int lat, output logic err,
                      output logic [63:0] rdata, output logic strobed);
    lat = -1; err = 1'b0; rdata = '0; strobed = 1'b0;
    b_addr = addr; b_read = 1'b1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clock);
      if (b_sread || b_swrite) strobed = 1'b1;
      if (b_ready) begin lat = c; err = b_error; rdata = b_rdata; end
    end
    b_read = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    int          missed;
    logic        err;
    logic        strobed;
    logic        seen_ready;
    logic [63:0] rdata;

    vecs[0] = '{64'hFFFF_1008, 64'h0,    1'b1, 1'b0, 0,    1'b0, 1,  4'b0010, 12'h008, 1'b0, 64'h1234, 2, 1};
    vecs[1] = '{64'hFFFF_3000, 64'hDEAD, 1'b0, 1'b1, 5,    1'b0, 1,  4'b1000, 12'h000, 1'b0, 64'h1234, 7, 6};
    vecs[2] = '{64'h0000_1000, 64'h0,    1'b1, 1'b0, 0,    1'b0, 1,  4'b0000, 12'h000, 1'b1, ONES,     1, 0};
    vecs[3] = '{64'hFFFF_2010, 64'h0,    1'b1, 1'b0, 1000, 1'b0, 1,  4'b0100, 12'h010, 1'b1, ONES,     9, 8};
    vecs[4] = '{64'hFFFF_0FF8, 64'h0,    1'b1, 1'b0, 2,    1'b0, 10, 4'b0001, 12'hFF8, 1'b0, 64'hAAA0, 4, 3};
    vecs[5] = '{64'hFFFF_1000, 64'h77,   1'b1, 1'b1, 0,    1'b0, 1,  4'b0000, 12'h000, 1'b1, ONES,     1, 0};
    vecs[6] = '{64'hFFFF_2000, 64'h0,    1'b1, 1'b0, 7,    1'b0, 1,  4'b0100, 12'h000, 1'b0, 64'hBBB2, 9, 8};
    vecs[7] = '{64'hFFFF_3018, 64'h0,    1'b1, 1'b0, 3,    1'b1, 1,  4'b1000, 12'h018, 1'b0, 64'hCCC3, 5, 4};
    vecs[8] = '{64'hFFFF_0004, 64'h55,   1'b0, 1'b1, 1,    1'b0, 1,  4'b0001, 12'h004, 1'b0, 64'hCCC3, 3, 2};
    vecs[9] = '{64'h1_FFFF_1000, 64'h0,  1'b1, 1'b0, 0,    1'b0, 1,  4'b0000, 12'h000, 1'b1, ONES,     1, 0};

    n_applied = 0; n_miscompares = 0; exp_err_count = 0; exp_err_addr = '0;
    reset_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    b_addr = '0; b_read = 1'b0; ack_delay = 1000; ack_foreign = 1'b0;
    #1;
    checkOutput("reset strobes/ready", 64'({cpu_ready, cpu_error, slv_read, slv_write, slv_sel}), 64'd0);
    checkOutput("reset data outputs", cpu_rdata | slv_wdata | err_addr | 64'(slv_addr) | 64'(err_count), 64'd0);
    checkOutput("reset bridge b", 64'({b_ready, b_error, b_sread, b_swrite, b_sel, b_saddr, b_err_count}) | b_rdata | b_swdata | b_err_addr, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) applyStimulus(i, vecs[i]);

    // Three-slave bridge: index 3 lies inside the region but beyond the last slave.
    runB(64'hFFFF_3000, lat, err, rdata, strobed);
    checkOutput("b out-of-range latency", 64'(lat), 64'd1);
    checkOutput("b out-of-range error", 64'(err), 64'd1);
    checkOutput("b out-of-range rdata", rdata, ONES);
    checkOutput("b out-of-range strobe", 64'(strobed), 64'd0);
    checkOutput("b err_count", 64'(b_err_count), 64'd1);
    checkOutput("b err_addr", b_err_addr, 64'hFFFF_3000);
    runB(64'hFFFF_2008, lat, err, rdata, strobed);
    checkOutput("b slave2 latency", 64'(lat), 64'd2);
    checkOutput("b slave2 error", 64'(err), 64'd0);
    checkOutput("b slave2 rdata", rdata, 64'h2222);

    // Repeated timeouts drive the error counter into saturation.
    missed = 0;
    for (int t = 0; t < 300; t++) begin
      cpu_addr = 64'hFFFF_2000; cpu_read = 1'b1; ack_delay = 1000;
      seen_ready = 1'b0;
      for (int c = 0; c < 20 && !seen_ready; c++) begin
        @(negedge clock);
        if (cpu_ready) seen_ready = 1'b1;
      end
      if (!seen_ready) missed++;
      exp_err_count = (exp_err_count == 255) ? 255 : exp_err_count + 1;
      cpu_read = 1'b0;
      repeat (2) @(negedge clock);
    end
    checkOutput("saturation completions", 64'(missed), 64'd0);
    checkOutput("saturation err_count", 64'(err_count), 64'(exp_err_count));
    checkOutput("saturation err_addr", err_addr, 64'hFFFF_2000);

    // Reset in the middle of an access drops the strobes without completing.
    cpu_addr = 64'hFFFF_1000; cpu_read = 1'b1; ack_delay = 1000;
    repeat (3) @(negedge clock);
    checkOutput("pre-reset slv_read", 64'(slv_read), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset slv_read", 64'(slv_read), 64'd0);
    checkOutput("async reset slv_sel", 64'(slv_sel), 64'd0);
    checkOutput("async reset err_count", 64'(err_count), 64'd0);
    cpu_read = 1'b0;
    exp_err_count = 0;
    seen_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (cpu_ready) seen_ready = 1'b1;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (cpu_ready) seen_ready = 1'b1;
    end
    checkOutput("no completion after reset", 64'(seen_ready), 64'd0);
    applyStimulus(10, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
